// File: rtl/gradient_magnitude_seq_pkg.sv
// Shared types and width helpers for the sequential gradient-magnitude unit.
package gradient_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of gx^2 + gy^2 without truncation.
  function automatic int unsigned sum_w(input int unsigned in_w);
    return 2 * in_w + 1;
  endfunction

  // Width of the untruncated root; also the iteration count.
  function automatic int unsigned root_w(input int unsigned in_w);
    return in_w + 1;
  endfunction

  // Width of a counter able to hold the iteration count.
  function automatic int unsigned cnt_w(input int unsigned in_w);
    return $clog2(in_w + 2);
  endfunction

endpackage

// File: rtl/gradient_magnitude_seq_if.sv
// Operand/result handshake bundle for gradient_magnitude_seq.
interface gradient_magnitude_seq_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  gx;
  logic [IN_W-1:0]  gy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] g;
  logic             sat;
  logic             busy;

  modport master (
    output in_valid, gx, gy, out_ready,
    input  in_ready, out_valid, g, sat, busy
  );

  modport slave (
    input  in_valid, gx, gy, out_ready,
    output in_ready, out_valid, g, sat, busy
  );
endinterface

// File: rtl/gradient_magnitude_seq_isqrt_iter.sv
// Non-restoring integer square root, one root bit per step, MSB first.
module isqrt_iter #(
  parameter int unsigned SUM_W = 17
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   step,
  input  logic [SUM_W-1:0]       sum,
  output logic                   done,
  output logic [(SUM_W+1)/2-1:0] root,
  output logic [(SUM_W+1)/2:0]   rem
);
  localparam int unsigned ROOT_W = (SUM_W + 1) / 2;
  localparam int unsigned PAD_W  = 2 * ROOT_W;
  localparam int unsigned RW     = ROOT_W + 4;
  localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

  logic [PAD_W-1:0]  pad_q;
  logic [RW-1:0]     rem_q;
  logic [RW-1:0]     rem_d;
  logic [RW-1:0]     rem_sh_c;
  logic [ROOT_W-1:0] root_q;
  logic [ROOT_W-1:0] root_d;
  logic [CNT_W-1:0]  cnt_q;

  // One recurrence step: the remainder is kept signed in two's complement.
  always_comb begin
    rem_sh_c = (rem_q << 2) + RW'(pad_q[PAD_W-1 -: 2]);
    if (rem_q[RW-1]) begin
      rem_d = rem_sh_c + RW'({root_q, 2'b11});
    end else begin
      rem_d = rem_sh_c - RW'({root_q, 2'b01});
    end
    root_d = {root_q[ROOT_W-2:0], ~rem_d[RW-1]};
  end

  // Datapath registers: start loads the radicand, step consumes two bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      pad_q  <= PAD_W'(sum);
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (step) begin
      pad_q  <= pad_q << 2;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign done = step && (cnt_q == CNT_W'(ROOT_W - 1));
  assign root = root_q;
  // A negative final remainder is corrected by adding back 2*root+1.
  assign rem  = rem_q[RW-1] ? (rem_q[ROOT_W:0] + {root_q, 1'b1}) : rem_q[ROOT_W:0];

endmodule

// File: rtl/gradient_magnitude_seq.sv
// Sequential gradient magnitude g = sqrt(gx^2 + gy^2), saturated to OUT_W.
// Optional round-to-nearest result when GRADIENT_ROUND_EN is defined.
module gradient_magnitude_seq
  import gradient_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  gradient_magnitude_seq_if.slave  bus
);
  localparam int unsigned SUM_W  = sum_w(IN_W);
  localparam int unsigned ROOT_W = root_w(IN_W);
  localparam int unsigned RND_W  = ROOT_W + 1;
  localparam int unsigned CW     = ((RND_W > OUT_W) ? RND_W : OUT_W) + 1;
  localparam logic [CW-1:0] MAXV = CW'({OUT_W{1'b1}});

  state_t           state_q;
  logic [IN_W-1:0]  gx_q;
  logic [IN_W-1:0]  gy_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] g_q;
  logic             sat_q;

  logic              start_c;
  logic              step_c;
  logic              done_c;
  logic [SUM_W-1:0]  sum_c;
  logic [ROOT_W-1:0] root_c;
  logic [ROOT_W:0]   rem_c;
  logic              rnd_c;
  logic [RND_W-1:0]  root_rnd_c;
  logic [CW-1:0]     mag_c;
  logic              sat_c;
  logic [OUT_W-1:0]  g_c;

  assign start_c = (state_q == SQUARE);
  assign step_c  = (state_q == ROOT);
  assign sum_c   = SUM_W'(gx_q) * SUM_W'(gx_q) + SUM_W'(gy_q) * SUM_W'(gy_q);

  isqrt_iter #(.SUM_W(SUM_W)) u_iter (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start_c),
    .step  (step_c),
    .sum   (sum_c),
    .done  (done_c),
    .root  (root_c),
    .rem   (rem_c)
  );

`ifdef GRADIENT_ROUND_EN
  // Round up when the true root lies past root + 1/2.
  assign rnd_c = (rem_c > RND_W'(root_c));
`else
  logic rem_unused_c;
  assign rem_unused_c = ^rem_c;
  assign rnd_c        = 1'b0;
`endif

  // Rounding is applied before the clamp so sat reflects the final value.
  assign root_rnd_c = RND_W'(root_c) + RND_W'(rnd_c);
  assign mag_c      = CW'(root_rnd_c);
  assign sat_c      = (mag_c > MAXV);
  assign g_c        = sat_c ? {OUT_W{1'b1}} : OUT_W'(mag_c);

  // Control FSM, operand capture and registered result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      gx_q        <= '0;
      gy_q        <= '0;
      out_valid_q <= 1'b0;
      g_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            gx_q    <= bus.gx;
            gy_q    <= bus.gy;
            state_q <= SQUARE;
          end
        end
        SQUARE: state_q <= ROOT;
        ROOT: begin
          if (done_c) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            g_q         <= g_c;
            sat_q       <= sat_c;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.g         = g_q;
  assign bus.sat       = sat_q;

endmodule
